// File: rtl/ucak_pkg.sv
// Shared types and default constants for the boarding-gate controller.
//   durum_e : session state, encoded as reported on durum_o
//   *_VARSAYILAN : default parameter values of ucak_binis_kapi
package ucak_pkg;

    typedef enum logic [1:0] {
        StBosta   = 2'd0,
        StOncelik = 2'd1,
        StBinis   = 2'd2,
        StKalkis  = 2'd3
    } durum_e;

    localparam int unsigned KAPASITE_VARSAYILAN     = 50;
    localparam int unsigned KAPI_SAYISI_VARSAYILAN  = 4;
    localparam int unsigned ONCELIK_SURE_VARSAYILAN = 16;
    localparam int unsigned ZAMAN_ASIMI_VARSAYILAN  = 1000;

endpackage

// File: rtl/rr_hakem.sv
// Round-robin arbiter.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   istek_i       : request vector, one bit per gate
//   izin_en_i     : when high, a grant moves the pointer past the granted gate
//   izin_o        : one-hot grant (zero when nothing is requested)
// The pointer names the gate with highest priority; it starts at gate 0.
module rr_hakem #(
    parameter int unsigned KAPI_SAYISI = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic [KAPI_SAYISI-1:0] istek_i,
    input  logic                   izin_en_i,
    output logic [KAPI_SAYISI-1:0] izin_o
);

    localparam int unsigned PtrW = (KAPI_SAYISI > 1) ? $clog2(KAPI_SAYISI) : 1;

    logic [PtrW-1:0] ptr_q, ptr_d;
    logic [PtrW-1:0] idx;
    int unsigned     aday;
    logic            bulundu;

    // Scan gates starting at the pointer; the first requester wins.
    always_comb begin
        izin_o  = '0;
        ptr_d   = ptr_q;
        bulundu = 1'b0;
        aday    = 0;
        idx     = '0;
        for (int unsigned i = 0; i < KAPI_SAYISI; i++) begin
            aday = (32'(ptr_q) + i) % KAPI_SAYISI;
            idx  = PtrW'(aday);
            if (!bulundu && istek_i[idx]) begin
                bulundu     = 1'b1;
                izin_o[idx] = 1'b1;
                if (izin_en_i) begin
                    ptr_d = PtrW'((aday + 1) % KAPI_SAYISI);
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/ucak_binis_kapi.sv
// Aircraft boarding-gate controller.
//   saat_i, reset_ni        : clock, asynchronous active-low reset
//   basla_i, iptal_i        : start a session / abort to idle (abort dominates)
//   yolcu_gecerli_i         : per-gate passenger present
//   g_kimlik_i              : per-gate ID valid
//   oncelikli_i             : per-gate priority passenger
//   yolcu_kabul_o / _red_o  : one-hot accept / reject of the granted gate (combinational)
//   yolcu_sayisi_o          : boarded count, saturates at KAPASITE
//   kalkis_o, bitti_o       : departure level, one-cycle pulse on departure entry
//   durum_o                 : current state
module ucak_binis_kapi
    import ucak_pkg::*;
#(
    parameter int unsigned KAPASITE     = KAPASITE_VARSAYILAN,
    parameter int unsigned KAPI_SAYISI  = KAPI_SAYISI_VARSAYILAN,
    parameter int unsigned ONCELIK_SURE = ONCELIK_SURE_VARSAYILAN,
    parameter int unsigned ZAMAN_ASIMI  = ZAMAN_ASIMI_VARSAYILAN,
    localparam int unsigned SAYAC_W     = $clog2(KAPASITE + 1)
) (
    input  logic                   saat_i,
    input  logic                   reset_ni,
    input  logic                   basla_i,
    input  logic                   iptal_i,
    input  logic [KAPI_SAYISI-1:0] yolcu_gecerli_i,
    input  logic [KAPI_SAYISI-1:0] g_kimlik_i,
    input  logic [KAPI_SAYISI-1:0] oncelikli_i,
    output logic [KAPI_SAYISI-1:0] yolcu_kabul_o,
    output logic [KAPI_SAYISI-1:0] yolcu_red_o,
    output logic [SAYAC_W-1:0]     yolcu_sayisi_o,
    output logic                   kalkis_o,
    output logic                   bitti_o,
    output logic [1:0]             durum_o
);

    localparam int unsigned OncW  = $clog2(ONCELIK_SURE + 1);
    localparam int unsigned AsimW = $clog2(ZAMAN_ASIMI + 1);

    durum_e             durum_q, durum_d;
    logic [SAYAC_W-1:0] sayi_q, sayi_d;
    logic [OncW-1:0]    onc_q, onc_d;
    logic [AsimW-1:0]   asim_q, asim_d;
    logic               bitti_q, bitti_d;

    logic [KAPI_SAYISI-1:0] istek, izin;
    logic                   dolu, kabul_var, son_yolcu;

    // Abort suppresses every grant so the pointer does not move either.
    always_comb begin
        istek = '0;
        if (!iptal_i) begin
            unique case (durum_q)
                StOncelik: istek = yolcu_gecerli_i & oncelikli_i;
                StBinis:   istek = yolcu_gecerli_i;
                default:   istek = '0;
            endcase
        end
    end

    rr_hakem #(
        .KAPI_SAYISI(KAPI_SAYISI)
    ) u_hakem (
        .clk_i    (saat_i),
        .rst_ni   (reset_ni),
        .istek_i  (istek),
        .izin_en_i(|istek),
        .izin_o   (izin)
    );

    assign dolu          = (sayi_q >= SAYAC_W'(KAPASITE));
    assign yolcu_kabul_o = izin & g_kimlik_i & {KAPI_SAYISI{!dolu}};
    assign yolcu_red_o   = izin & ~g_kimlik_i;
    assign kabul_var     = |yolcu_kabul_o;
    assign son_yolcu     = kabul_var && (sayi_q == SAYAC_W'(KAPASITE - 1));

    always_comb begin
        durum_d = durum_q;
        sayi_d  = sayi_q;
        onc_d   = onc_q;
        asim_d  = asim_q;
        if (iptal_i) begin
            durum_d = StBosta;
            sayi_d  = '0;
            onc_d   = '0;
            asim_d  = '0;
        end else begin
            unique case (durum_q)
                StBosta, StKalkis: begin
                    if (basla_i) begin
                        durum_d = StOncelik;
                        sayi_d  = '0;
                        onc_d   = '0;
                        asim_d  = '0;
                    end
                end
                StOncelik: begin
                    onc_d = onc_q + OncW'(1);
                    if (kabul_var) begin
                        sayi_d = sayi_q + SAYAC_W'(1);
                    end
                    if (son_yolcu) begin
                        durum_d = StKalkis;
                    end else if (onc_q == OncW'(ONCELIK_SURE - 1)) begin
                        durum_d = StBinis;
                        asim_d  = '0;
                    end
                end
                StBinis: begin
                    if (kabul_var) begin
                        sayi_d = sayi_q + SAYAC_W'(1);
                        asim_d = '0;
                    end else begin
                        asim_d = asim_q + AsimW'(1);
                    end
                    if (son_yolcu) begin
                        durum_d = StKalkis;
                    end else if (!kabul_var && asim_q == AsimW'(ZAMAN_ASIMI - 1)) begin
                        durum_d = StKalkis;
                    end
                end
                default: durum_d = StBosta;
            endcase
        end
        bitti_d = (durum_d == StKalkis) && (durum_q != StKalkis);
    end

    always_ff @(posedge saat_i or negedge reset_ni) begin
        if (!reset_ni) begin
            durum_q <= StBosta;
            sayi_q  <= '0;
            onc_q   <= '0;
            asim_q  <= '0;
            bitti_q <= 1'b0;
        end else begin
            durum_q <= durum_d;
            sayi_q  <= sayi_d;
            onc_q   <= onc_d;
            asim_q  <= asim_d;
            bitti_q <= bitti_d;
        end
    end

    assign yolcu_sayisi_o = sayi_q;
    assign kalkis_o       = (durum_q == StKalkis);
    assign bitti_o        = bitti_q;
    assign durum_o        = durum_q;

endmodule

// File: tb/tb_ucak_binis_kapi.sv
// Bench for ucak_binis_kapi: directed scenarios plus random traffic against a
// cycle-level reference model kept in plain integers.
module tb_ucak_binis_kapi;

    localparam int unsigned KAP = 3;
    localparam int unsigned KS  = 2;
    localparam int unsigned OS  = 4;
    localparam int unsigned ZA  = 8;
    localparam int unsigned SW  = 2;

    logic          saat = 1'b0;
    logic          reset_n;
    logic          basla, iptal;
    logic [KS-1:0] gec, kim, onc;
    logic [KS-1:0] kabul, red;
    logic [SW-1:0] sayi;
    logic          kalkis, bitti;
    logic [1:0]    durum;

    int tests = 0;
    int fails = 0;

    // Reference model: state code, count, cycles spent in priority phase,
    // consecutive no-accept cycles in boarding, last granted gate, bitti.
    int   m_durum, m_sayi, m_onc, m_bos, m_son;
    logic m_bitti;

    logic [9:0]    exp_vec, obs_vec;
    logic [KS-1:0] o_kabul, o_red;
    logic [SW-1:0] o_sayi;
    logic [1:0]    o_durum;
    logic          o_kalkis, o_bitti;

    always #5 saat = ~saat;

    ucak_binis_kapi #(
        .KAPASITE    (KAP),
        .KAPI_SAYISI (KS),
        .ONCELIK_SURE(OS),
        .ZAMAN_ASIMI (ZA)
    ) dut (
        .saat_i         (saat),
        .reset_ni       (reset_n),
        .basla_i        (basla),
        .iptal_i        (iptal),
        .yolcu_gecerli_i(gec),
        .g_kimlik_i     (kim),
        .oncelikli_i    (onc),
        .yolcu_kabul_o  (kabul),
        .yolcu_red_o    (red),
        .yolcu_sayisi_o (sayi),
        .kalkis_o       (kalkis),
        .bitti_o        (bitti),
        .durum_o        (durum)
    );

    task automatic model_reset();
        m_durum = 0;
        m_sayi  = 0;
        m_onc   = 0;
        m_bos   = 0;
        m_son   = KS - 1;
        m_bitti = 1'b0;
    endtask

    // One clock cycle: drive (just after posedge), predict, sample at negedge,
    // then advance the model across the next posedge.
    task automatic adim(input logic b, input logic ip, input logic [KS-1:0] g,
                        input logic [KS-1:0] k, input logic [KS-1:0] o);
        int            gi;
        logic          acc;
        logic [KS-1:0] e_kabul, e_red;
        basla = b;
        iptal = ip;
        gec   = g;
        kim   = k;
        onc   = o;
        gi      = -1;
        acc     = 1'b0;
        e_kabul = '0;
        e_red   = '0;
        if (!ip && (m_durum == 1 || m_durum == 2)) begin
            for (int s = 1; s <= KS; s++) begin
                int c;
                c = (m_son + s) % KS;
                if (gi < 0 && g[c] && (m_durum == 2 || o[c])) gi = c;
            end
        end
        if (gi >= 0) begin
            if (!k[gi]) e_red[gi] = 1'b1;
            else if (m_sayi < KAP) begin
                e_kabul[gi] = 1'b1;
                acc = 1'b1;
            end
        end
        exp_vec = {e_kabul, e_red, SW'(m_sayi), 2'(m_durum), (m_durum == 3), m_bitti};
        #4;
        o_kabul  = kabul;
        o_red    = red;
        o_sayi   = sayi;
        o_durum  = durum;
        o_kalkis = kalkis;
        o_bitti  = bitti;
        obs_vec  = {kabul, red, sayi, durum, kalkis, bitti};
        @(posedge saat);
        #1;
        m_bitti = 1'b0;
        if (gi >= 0) m_son = gi;
        if (ip) begin
            m_durum = 0; m_sayi = 0; m_onc = 0; m_bos = 0;
        end else begin
            case (m_durum)
                0, 3: if (b) begin
                    m_durum = 1; m_sayi = 0; m_onc = 0; m_bos = 0;
                end
                1: begin
                    m_onc++;
                    if (acc) m_sayi++;
                    if (acc && m_sayi == KAP) begin
                        m_durum = 3; m_bitti = 1'b1;
                    end else if (m_onc == OS) begin
                        m_durum = 2; m_bos = 0;
                    end
                end
                default: begin
                    if (acc) begin
                        m_sayi++; m_bos = 0;
                    end else m_bos++;
                    if (acc && m_sayi == KAP) begin
                        m_durum = 3; m_bitti = 1'b1;
                    end else if (!acc && m_bos == ZA) begin
                        m_durum = 3; m_bitti = 1'b1;
                    end
                end
            endcase
        end
    endtask

    task automatic test_reset();
        model_reset();
        #3;
        tests++;
        if ({kabul, red, sayi, durum, kalkis, bitti} !== 10'b0) begin
            fails++;
            $display("FAIL reset_state got=%b want=%b", {kabul, red, sayi, durum, kalkis, bitti}, 10'b0);
        end
        gec = 2'b11; kim = 2'b11; onc = 2'b11; basla = 1'b1;
        #1;
        tests++;
        if ({kabul, red} !== 4'b0) begin
            fails++;
            $display("FAIL reset_no_grant got=%b want=%b", {kabul, red}, 4'b0);
        end
        @(posedge saat);
        #1;
        reset_n = 1'b1;
        basla = 1'b0; gec = '0; kim = '0; onc = '0;
    endtask

    task automatic test_full_load();
        int            bitti_say = 0;
        int            onc_bos   = 0;
        logic [KS-1:0] seq[$];
        logic [5:0]    seq_v;
        for (int i = 0; i < 10; i++) begin
            if (i == 0) adim(1'b1, 1'b0, 2'b00, 2'b00, 2'b00);
            else        adim(1'b0, 1'b0, 2'b11, 2'b11, 2'b00);
            tests++;
            if (obs_vec !== exp_vec) begin
                fails++;
                $display("FAIL full_load cyc=%0d got=%b want=%b", i, obs_vec, exp_vec);
            end
            if (o_durum == 2'd1 && o_kabul == '0) onc_bos++;
            if (o_kabul != '0) seq.push_back(o_kabul);
            if (o_bitti) bitti_say++;
        end
        seq_v = (seq.size() == 3) ? {seq[0], seq[1], seq[2]} : 6'b111111;
        tests++;
        if (onc_bos !== OS) begin
            fails++; $display("FAIL full_priority_wait got=%0d want=%0d", onc_bos, OS);
        end
        tests++;
        if (seq_v !== 6'b01_10_01) begin
            fails++; $display("FAIL full_rr_order got=%b want=%b", seq_v, 6'b011001);
        end
        tests++;
        if (bitti_say !== 1) begin
            fails++; $display("FAIL full_bitti_pulses got=%0d want=1", bitti_say);
        end
        tests++;
        if ({o_durum, o_sayi, o_kalkis} !== {2'd3, 2'd3, 1'b1}) begin
            fails++; $display("FAIL full_end got=%b want=%b", {o_durum, o_sayi, o_kalkis}, 5'b11111);
        end
    endtask

    task automatic test_priority();
        logic          g0 = 1'b1, g1 = 1'b1;
        int            erken0 = 0;
        logic [KS-1:0] ilk = '0;
        for (int i = 0; i < 12; i++) begin
            if (i == 0) adim(1'b1, 1'b0, 2'b00, 2'b00, 2'b00);
            else        adim(1'b0, 1'b0, {g1, g0}, 2'b11, 2'b10);
            tests++;
            if (obs_vec !== exp_vec) begin
                fails++;
                $display("FAIL priority cyc=%0d got=%b want=%b", i, obs_vec, exp_vec);
            end
            if (o_durum == 2'd1 && o_kabul[0]) erken0++;
            if (ilk == '0 && o_kabul != '0) ilk = o_kabul;
            if (o_kabul[1]) g1 = 1'b0;
            if (o_kabul[0]) g0 = 1'b0;
        end
        tests++;
        if (ilk !== 2'b10) begin
            fails++; $display("FAIL priority_first got=%b want=%b", ilk, 2'b10);
        end
        tests++;
        if (erken0 !== 0 || g0 !== 1'b0) begin
            fails++; $display("FAIL priority_gate0 early=%0d pending=%b want 0,0", erken0, g0);
        end
    endtask

    task automatic test_reject();
        for (int i = 0; i < 9; i++) begin
            if (i == 0)      adim(1'b0, 1'b1, 2'b00, 2'b00, 2'b00);
            else if (i == 1) adim(1'b1, 1'b0, 2'b00, 2'b00, 2'b00);
            else if (i < 6)  adim(1'b0, 1'b0, 2'b00, 2'b00, 2'b00);
            else if (i < 8)  adim(1'b0, 1'b0, 2'b01, 2'b00, 2'b00);
            else             adim(1'b0, 1'b0, 2'b01, 2'b01, 2'b00);
            tests++;
            if (obs_vec !== exp_vec) begin
                fails++;
                $display("FAIL reject cyc=%0d got=%b want=%b", i, obs_vec, exp_vec);
            end
            if (i == 6 || i == 7) begin
                tests++;
                if ({o_red, o_kabul, o_sayi} !== {2'b01, 2'b00, 2'd0}) begin
                    fails++;
                    $display("FAIL reject_bad_id cyc=%0d got=%b want=%b", i,
                             {o_red, o_kabul, o_sayi}, 6'b010000);
                end
            end
            if (i == 8) begin
                tests++;
                if ({o_red, o_kabul} !== {2'b00, 2'b01}) begin
                    fails++;
                    $display("FAIL reject_then_accept got=%b want=%b", {o_red, o_kabul}, 4'b0001);
                end
            end
        end
    endtask

    task automatic test_timeout();
        int binis_say = 0;
        int bitti_say = 0;
        for (int i = 0; i < 12; i++) begin
            adim(1'b0, 1'b0, 2'b00, 2'b00, 2'b00);
            tests++;
            if (obs_vec !== exp_vec) begin
                fails++;
                $display("FAIL timeout cyc=%0d got=%b want=%b", i, obs_vec, exp_vec);
            end
            if (o_durum == 2'd2) binis_say++;
            if (o_bitti) bitti_say++;
        end
        tests++;
        if (binis_say !== ZA || bitti_say !== 1) begin
            fails++;
            $display("FAIL timeout_len binis=%0d bitti=%0d want %0d,1", binis_say, bitti_say, ZA);
        end
        tests++;
        if ({o_durum, o_sayi, o_kalkis} !== {2'd3, 2'd1, 1'b1}) begin
            fails++; $display("FAIL timeout_end got=%b want=%b", {o_durum, o_sayi, o_kalkis}, 5'b11011);
        end
    endtask

    task automatic test_abort();
        int bitti_say = 0;
        for (int i = 0; i < 9; i++) begin
            if (i == 0)      adim(1'b1, 1'b0, 2'b00, 2'b00, 2'b00);
            else if (i < 5)  adim(1'b0, 1'b0, 2'b00, 2'b00, 2'b00);
            else if (i == 5) adim(1'b0, 1'b0, 2'b01, 2'b01, 2'b00);
            else if (i == 6) adim(1'b1, 1'b1, 2'b01, 2'b01, 2'b00);
            else             adim(1'b0, 1'b0, 2'b00, 2'b00, 2'b00);
            tests++;
            if (obs_vec !== exp_vec) begin
                fails++;
                $display("FAIL abort cyc=%0d got=%b want=%b", i, obs_vec, exp_vec);
            end
            if (i >= 6 && o_bitti) bitti_say++;
            if (i == 6) begin
                tests++;
                if ({o_kabul, o_red} !== 4'b0) begin
                    fails++; $display("FAIL abort_no_grant got=%b want=%b", {o_kabul, o_red}, 4'b0);
                end
            end
            if (i == 7) begin
                tests++;
                if ({o_durum, o_sayi, o_kalkis} !== 5'b0) begin
                    fails++;
                    $display("FAIL abort_idle got=%b want=%b", {o_durum, o_sayi, o_kalkis}, 5'b0);
                end
            end
        end
        tests++;
        if (bitti_say !== 0) begin
            fails++; $display("FAIL abort_bitti got=%0d want=0", bitti_say);
        end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 6; i++) begin
            if (i == 0)     adim(1'b1, 1'b0, 2'b00, 2'b00, 2'b00);
            else if (i < 5) adim(1'b0, 1'b0, 2'b00, 2'b00, 2'b00);
            else            adim(1'b0, 1'b0, 2'b01, 2'b01, 2'b00);
            tests++;
            if (obs_vec !== exp_vec) begin
                fails++;
                $display("FAIL async_pre cyc=%0d got=%b want=%b", i, obs_vec, exp_vec);
            end
        end
        gec = 2'b10; kim = 2'b10;
        #2;
        reset_n = 1'b0;
        #1;
        tests++;
        if ({kabul, red, sayi, durum, kalkis, bitti} !== 10'b0) begin
            fails++;
            $display("FAIL async_clear got=%b want=%b", {kabul, red, sayi, durum, kalkis, bitti}, 10'b0);
        end
        model_reset();
        @(posedge saat);
        #1;
        reset_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (i == 0)     adim(1'b1, 1'b0, 2'b00, 2'b00, 2'b00);
            else if (i < 5) adim(1'b0, 1'b0, 2'b00, 2'b00, 2'b00);
            else            adim(1'b0, 1'b0, 2'b11, 2'b11, 2'b00);
            tests++;
            if (obs_vec !== exp_vec) begin
                fails++;
                $display("FAIL async_post cyc=%0d got=%b want=%b", i, obs_vec, exp_vec);
            end
        end
        tests++;
        if ({o_kabul, o_sayi} !== {2'b01, 2'd0}) begin
            fails++; $display("FAIL async_pointer got=%b want=%b", {o_kabul, o_sayi}, 4'b0100);
        end
    endtask

    task automatic test_random();
        logic          b, ip;
        logic [KS-1:0] g, k, o;
        for (int i = 0; i < 600; i++) begin
            b  = ($urandom_range(0, 9) == 0);
            ip = ($urandom_range(0, 59) == 0);
            g  = KS'($urandom);
            o  = KS'($urandom);
            for (int j = 0; j < KS; j++) k[j] = ($urandom_range(0, 3) != 0);
            adim(b, ip, g, k, o);
            tests++;
            if (obs_vec !== exp_vec) begin
                fails++;
                $display("FAIL random cyc=%0d got=%b want=%b", i, obs_vec, exp_vec);
            end
        end
    endtask

    initial begin
        reset_n = 1'b0;
        basla   = 1'b0;
        iptal   = 1'b0;
        gec     = '0;
        kim     = '0;
        onc     = '0;
        test_reset();
        test_full_load();
        test_priority();
        test_reject();
        test_timeout();
        test_abort();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ucak_binis_kapi.md
UCAK_BINIS_KAPI -- requirements
Module: ucak_binis_kapi

Interface
REQ-001 Parameter KAPASITE, default 50: seat count; boarding closes at this count.
REQ-002 Parameter KAPI_SAYISI, default 4: number of boarding gates (channels), range 1..8.
REQ-003 Parameter ONCELIK_SURE, default 16: length of the priority-boarding phase, in cycles.
REQ-004 Parameter ZAMAN_ASIMI, default 1000: consecutive no-accept cycles in BINIS that force departure.
REQ-005 Derived SAYAC_W = clog2(KAPASITE+1).
REQ-006 saat  in  1  single clock; all state updates on rising edge.
REQ-007 reset  in  1  asynchronous, active-low reset.
REQ-008 basla  in  1  start a new boarding session.
REQ-009 iptal  in  1  abort the session.
REQ-010 yolcu_gecerli  in  KAPI_SAYISI  per-gate passenger present; held until kabul or red.
REQ-011 g_kimlik  in  KAPI_SAYISI  per-gate ID valid, qualified by yolcu_gecerli.
REQ-012 oncelikli  in  KAPI_SAYISI  per-gate priority-passenger flag.
REQ-013 yolcu_kabul  out  KAPI_SAYISI  one-hot or zero; passenger boarded this cycle.
REQ-014 yolcu_red  out  KAPI_SAYISI  one-hot or zero; passenger rejected (bad ID) this cycle.
REQ-015 yolcu_sayisi  out  SAYAC_W  boarded count.
REQ-016 kalkis  out  1  departure; level.
REQ-017 bitti  out  1  one-cycle pulse on KALKIS entry.
REQ-018 durum  out  2  current state encoding.

Function
REQ-019 States: BOSTA=0, ONCELIK=1, BINIS=2, KALKIS=3; durum reflects the current state.
REQ-020 BOSTA or KALKIS with basla=1 and iptal=0 -> ONCELIK; clear yolcu_sayisi, the phase timer and kalkis.
REQ-021 basla is ignored in ONCELIK and BINIS.
REQ-022 ONCELIK -> BINIS after ONCELIK_SURE cycles in ONCELIK.
REQ-023 In ONCELIK, only gates with yolcu_gecerli and oncelikli both high are eligible.
REQ-024 In BINIS, every gate with yolcu_gecerli high is eligible.
REQ-025 No gate is eligible in BOSTA or KALKIS.
REQ-026 At most one eligible gate is granted per cycle, chosen round-robin starting after the last granted gate.
REQ-027 After reset, the round-robin pointer starts at gate 0.
REQ-028 Granted gate with g_kimlik=1 and yolcu_sayisi<KAPASITE: yolcu_kabul bit is high in the same cycle (combinational), and yolcu_sayisi increments at the next edge.
REQ-029 Granted gate with g_kimlik=0: yolcu_red bit is high in the same cycle, and the count is unchanged.
REQ-030 The round-robin pointer advances on both accept and reject.
REQ-031 yolcu_kabul and yolcu_red are never both high, and neither is high for an ungranted gate.
REQ-032 When an accept makes the count equal KAPASITE (in ONCELIK or BINIS), the state is KALKIS at the next edge.
REQ-033 In BINIS, ZAMAN_ASIMI consecutive cycles without an accept -> KALKIS, even with a partial load.
REQ-034 The no-accept counter clears on every accept and on entry to BINIS.
REQ-035 In KALKIS, kalkis=1; bitti=1 only in the first cycle after entry.
REQ-036 yolcu_sayisi holds its value in KALKIS.
REQ-037 yolcu_sayisi never exceeds KAPASITE.
REQ-038 yolcu_sayisi saturates at KAPASITE with no wrap-around.
REQ-039 iptal=1 in any state -> BOSTA at the next edge; clear the count, kalkis and timers; no bitti pulse.
REQ-040 iptal takes priority over basla, over accept and over full/timeout transitions in the same cycle.

Reset
REQ-041 reset=0 asynchronously forces: state BOSTA, yolcu_sayisi=0, kalkis=0, bitti=0, all timers 0, round-robin pointer 0.
REQ-042 A reset mid-session discards the session entirely.
REQ-043 While reset=0, yolcu_kabul and yolcu_red are 0.

Structure
REQ-044 Package ucak_pkg holds the state enum, state encodings and the default parameter constants.
REQ-045 Sub-module rr_hakem (parametrised by KAPI_SAYISI) holds the round-robin arbiter: request vector in, one-hot grant out, pointer update on a grant-enable input.

Verification (KAPASITE=3, KAPI_SAYISI=2, ONCELIK_SURE=4, ZAMAN_ASIMI=8)
REQ-046 Pulse basla, then hold gecerli=11, kimlik=11, oncelikli=00 -> no grant for 4 cycles; then kabul alternates 01,10,01; count 1,2,3; KALKIS; bitti pulses once.
REQ-047 In ONCELIK, gecerli=11, oncelikli=10 -> only kabul=10 is granted, and gate 0 waits until BINIS.
REQ-048 In BINIS, gecerli=01, kimlik=00 -> red=01 and the count is unchanged; kimlik then rises to 01 -> kabul=01.
REQ-049 In BINIS with count=1 and no gecerli for 8 cycles -> KALKIS, count=1, kalkis=1, bitti pulses.
REQ-050 iptal and basla together with an accept pending -> BOSTA, count=0, no kabul, no bitti.
REQ-051 Assert reset=0 asynchronously mid-BINIS -> outputs clear before the next edge; after release, basla restarts with count 0 and the pointer at gate 0.
